// File: rtl/pipe_reg_skid_if.sv
// rtl/pipe_reg_skid_if.sv - valid/ready handshake bundle between two pipeline stages
interface pipe_reg_skid_if #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;

  // Stage view: consumes upstream beats, produces downstream beats.
  modport slave (
    input  in_valid_i, data_i, ctrl_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, ctrl_o
  );

  // Environment view: drives upstream beats and downstream ready.
  modport master (
    output in_valid_i, data_i, ctrl_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, ctrl_o
  );
endinterface

// File: rtl/pipe_reg_skid.sv
// rtl/pipe_reg_skid.sv - pipeline stage register with 2-entry skid buffer, flush, freeze and stall counter
module pipe_reg_skid #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 flush_i,
  input  logic                 stall_clr_i,
  pipe_reg_skid_if.slave       bus,
  output logic [1:0]           occupancy_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_n;
  logic [DATA_W-1:0] main_data, main_data_n;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_n;
  logic [DATA_W-1:0] skid_data, skid_data_n;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_n;
  logic              in_ready, out_valid, accept, emit;

  // Handshake: upstream ready depends only on state and local enables, never on out_ready.
  always_comb begin
    in_ready  = start_i & ~flush_i & (state != FULL);
    out_valid = start_i & (state != EMPTY);
    accept    = bus.in_valid_i & in_ready;
    emit      = out_valid & bus.out_ready_i;
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.data_o      = main_data;
  assign bus.ctrl_o      = main_ctrl & {CTRL_W{out_valid}};
  assign occupancy_o     = state;

  // Next-state and register-load selection; flush beats freeze, which beats normal flow.
  always_comb begin
    state_n     = state;
    main_data_n = main_data;
    main_ctrl_n = main_ctrl;
    skid_data_n = skid_data;
    skid_ctrl_n = skid_ctrl;
    if (flush_i) begin
      state_n     = EMPTY;
      main_ctrl_n = '0;
      skid_ctrl_n = '0;
    end else if (start_i) begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_n     = ONE;
            main_data_n = bus.data_i;
            main_ctrl_n = bus.ctrl_i;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_data_n = bus.data_i;
            main_ctrl_n = bus.ctrl_i;
          end else if (accept) begin
            state_n     = FULL;
            skid_data_n = bus.data_i;
            skid_ctrl_n = bus.ctrl_i;
          end else if (emit) begin
            state_n     = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state_n     = ONE;
            main_data_n = skid_data;
            main_ctrl_n = skid_ctrl;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // State and storage registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state     <= state_n;
      main_data <= main_data_n;
      main_ctrl <= main_ctrl_n;
      skid_data <= skid_data_n;
      skid_ctrl <= skid_ctrl_n;
    end
  end

  // Saturating count of cycles where a beat waits on downstream; clear wins over increment.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (stall_clr_i) begin
      stall_cnt_o <= '0;
    end else if (out_valid && !bus.out_ready_i && (stall_cnt_o != CNT_MAX)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule
